cluster_clock_switch_ctrl: RTL and testbench
============================================

// Module: cluster_clock_switch_ctrl
// PURPOSE
//  Sequencer for the cluster 2:1 clock mux: owns clk_sel, performs software-requested source
//  switches safely (wait FLL lock, gate cluster clock, switch, settle, ungate), and falls back
//  autonomously to clk0 (reference) on FLL lock loss. Runs on always-on reference clock in SoC ctrl.
// PARAMETERS
//  SETTLE_CYCLES  8     cycles held gated after clk_sel_o changes (>=1)
//  LOCK_TIMEOUT   1023  max cycles in WAIT_LOCK before abort (>=1)
//  CNT_W = $clog2(max(SETTLE_CYCLES,LOCK_TIMEOUT)+1), localparam
// PORTS
//  clk_i            in   1  reference clock (always on); single clock domain
//  rst_i            in   1  asynchronous reset, active-high
//  switch_req_i     in   1  start switch; sampled only in IDLE, ignored while busy_o=1
//  switch_target_i  in   1  requested source: 0=clk0 (ref), 1=clk1 (FLL); sampled with req
//  fll_lock_i       in   1  FLL lock, asynchronous; 2-flop synchronised internally (lock_s)
//  clk_gate_ack_i   in   1  cluster clock gate status: 1=gated
//  err_clr_i        in   1  clears error_o and lock_lost_o
//  clk_sel_o        out  1  to mux clk_sel_i; registered
//  clk_gate_req_o   out  1  request cluster clock gating; registered
//  busy_o           out  1  state != IDLE
//  done_o           out  1  one-cycle pulse: switch completed
//  error_o          out  1  sticky: lock timeout abort
//  lock_lost_o      out  1  sticky: autonomous fallback occurred
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, clk_sel_o=0, clk_gate_req_o=0, done_o=0, error_o=0,
//   lock_lost_o=0, sync flops=0, counter=0, target reg=0. Mid-operation reset forces clk0.
//  States IDLE, WAIT_LOCK, GATE, SETTLE, UNGATE (all transitions on clk_i edge):
//  IDLE: priority 1: clk_sel_o=1 && lock_s=0 -> target=0, lock_lost_o<=1, GATE (a same-cycle
//   switch_req_i is dropped). priority 2: switch_req_i=1 -> latch target;
//   target==clk_sel_o -> stay IDLE, done_o pulse next cycle, no gating;
//   target=1 -> WAIT_LOCK (counter<=0); target=0 -> GATE.
//  WAIT_LOCK: lock_s=1 -> GATE. Else counter+1; counter==LOCK_TIMEOUT-1 with lock_s=0 ->
//   IDLE, error_o<=1, no done_o, clk_sel_o unchanged.
//  GATE: clk_gate_req_o=1 (set on entry edge). ack sampled 1 -> clk_sel_o<=target,
//   counter<=0, SETTLE. No timeout; waits indefinitely.
//  SETTLE: exactly SETTLE_CYCLES cycles; on last, clk_gate_req_o<=0, UNGATE.
//  UNGATE: ack sampled 0 -> IDLE, done_o=1 for one cycle.
//  clk_sel_o changes only on GATE->SETTLE edge, and only while ack=1 (cluster gated).
//  Lock loss outside IDLE is not acted on; re-evaluated on return to IDLE (fallback may
//   follow a completed switch to clk1 immediately, after its done_o).
//  err_clr_i and a new set of the same flag in one cycle: set wins.
//  Counter saturates; never wraps.
// TESTING
//  1 Reset then idle, lock_s=0, sel=0: clk_sel_o=0, gate_req=0, busy=0 for 100 cycles; no fallback.
//  2 fll_lock_i=1, req target=1, ack follows req after 1 cycle, SETTLE_CYCLES=8: WAIT_LOCK
//    passes, gate_req=1, sel 0->1 one cycle after ack seen, gate_req drops 8 cycles later,
//    done_o single pulse after ack=0, busy low; error_o=0.
//  3 fll_lock_i=0, req target=1, LOCK_TIMEOUT=16: busy for 16 cycles in WAIT_LOCK, then
//    error_o=1, clk_sel_o=0, gate_req never asserted, no done_o; err_clr_i clears error_o.
//  4 After test 2 (sel=1), drop fll_lock_i: within 3 cycles enter GATE, sel 1->0 after ack,
//    lock_lost_o=1, done_o pulse; switch_req_i issued same cycle as fallback is ignored.
//  5 Req target equal to current sel: done_o pulse next cycle, no gate_req, no sel change;
//    req while busy (in SETTLE) has no effect.
//  6 Assert rst_i during SETTLE with sel=1: clk_sel_o, gate_req, busy drop to 0 asynchronously.

Source files
------------

// File: rtl/cluster_clock_switch_ctrl.sv
// Sequencer for the cluster 2:1 clock mux: lock-gated source switches with gate/settle/ungate
// handshake, plus autonomous fallback to the reference clock on FLL lock loss.
`timescale 1ns/1ps

module cluster_clock_switch_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned LOCK_TIMEOUT  = 1023
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic switch_req_i,
  input  logic switch_target_i,
  input  logic fll_lock_i,
  input  logic clk_gate_ack_i,
  input  logic err_clr_i,
  output logic clk_sel_o,
  output logic clk_gate_req_o,
  output logic busy_o,
  output logic done_o,
  output logic error_o,
  output logic lock_lost_o
);

  localparam int unsigned CntMax = (SETTLE_CYCLES > LOCK_TIMEOUT) ? SETTLE_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned CNT_W  = $clog2(CntMax + 1);
  localparam logic [CNT_W-1:0] LockLast   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitLock,
    StGate,
    StSettle,
    StUngate
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             target_q;
  logic             lock_meta_q;
  logic             lock_s_q;

  // Saturating increment: the counter must never wrap back to zero.
  always_comb begin
    cnt_inc = cnt_q;
    if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_inc = cnt_q + CNT_W'(1);
    end
  end

  assign busy_o = (state_q != StIdle);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      target_q       <= 1'b0;
      lock_meta_q    <= 1'b0;
      lock_s_q       <= 1'b0;
      clk_sel_o      <= 1'b0;
      clk_gate_req_o <= 1'b0;
      done_o         <= 1'b0;
      error_o        <= 1'b0;
      lock_lost_o    <= 1'b0;
    end else begin
      lock_meta_q <= fll_lock_i;
      lock_s_q    <= lock_meta_q;
      done_o      <= 1'b0;

      // Clears come first so a same-cycle set below takes precedence.
      if (err_clr_i) begin
        error_o     <= 1'b0;
        lock_lost_o <= 1'b0;
      end

      case (state_q)
        StIdle: begin
          if (clk_sel_o && !lock_s_q) begin
            target_q       <= 1'b0;
            lock_lost_o    <= 1'b1;
            clk_gate_req_o <= 1'b1;
            state_q        <= StGate;
          end else if (switch_req_i) begin
            target_q <= switch_target_i;
            if (switch_target_i == clk_sel_o) begin
              done_o <= 1'b1;
            end else if (switch_target_i) begin
              cnt_q   <= '0;
              state_q <= StWaitLock;
            end else begin
              clk_gate_req_o <= 1'b1;
              state_q        <= StGate;
            end
          end
        end

        StWaitLock: begin
          if (lock_s_q) begin
            clk_gate_req_o <= 1'b1;
            state_q        <= StGate;
          end else if (cnt_q == LockLast) begin
            error_o <= 1'b1;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        StGate: begin
          // Mux select only moves while the cluster clock is confirmed gated.
          if (clk_gate_ack_i) begin
            clk_sel_o <= target_q;
            cnt_q     <= '0;
            state_q   <= StSettle;
          end
        end

        StSettle: begin
          if (cnt_q == SettleLast) begin
            clk_gate_req_o <= 1'b0;
            state_q        <= StUngate;
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        StUngate: begin
          if (!clk_gate_ack_i) begin
            done_o  <= 1'b1;
            state_q <= StIdle;
          end
        end

        default: begin
          clk_gate_req_o <= 1'b0;
          state_q        <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cluster_clock_switch_ctrl.sv
// Directed bench for cluster_clock_switch_ctrl: scenario expectations are queued when the
// request is driven and compared against the event timeline the DUT produces.
`timescale 1ns/1ps

module tb_cluster_clock_switch_ctrl;

  logic clk;
  logic rst;
  logic switch_req;
  logic switch_target;
  logic fll_lock;
  logic clk_gate_ack;
  logic err_clr;
  logic clk_sel_o;
  logic clk_gate_req_o;
  logic busy_o;
  logic done_o;
  logic error_o;
  logic lock_lost_o;

  int n_vec;
  int n_err;
  logic auto_ack;

  string tag_q[$];
  int    exp_q[$];

  int t_gate, t_sel, t_fall, t_done, n_done, n_busy, t_err, t_lost;

  cluster_clock_switch_ctrl #(
    .SETTLE_CYCLES(8),
    .LOCK_TIMEOUT (16)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .switch_req_i   (switch_req),
    .switch_target_i(switch_target),
    .fll_lock_i     (fll_lock),
    .clk_gate_ack_i (clk_gate_ack),
    .err_clr_i      (err_clr),
    .clk_sel_o      (clk_sel_o),
    .clk_gate_req_o (clk_gate_req_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .error_o        (error_o),
    .lock_lost_o    (lock_lost_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic sb_pop(input int obs);
    string t;
    int    e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL scoreboard_empty: got %0d want nothing queued", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      chk(t, obs, e);
    end
  endtask

  task automatic push_exp(input string tag, input int g, input int s, input int f, input int d,
                          input int nd, input int nb, input int te, input int tl,
                          input int sel, input int err, input int lost);
    sb_push({tag, ".gate_rise"}, g);
    sb_push({tag, ".sel_change"}, s);
    sb_push({tag, ".gate_fall"}, f);
    sb_push({tag, ".done_tick"}, d);
    sb_push({tag, ".done_count"}, nd);
    sb_push({tag, ".busy_cycles"}, nb);
    sb_push({tag, ".err_tick"}, te);
    sb_push({tag, ".lost_tick"}, tl);
    sb_push({tag, ".sel_end"}, sel);
    sb_push({tag, ".err_end"}, err);
    sb_push({tag, ".lost_end"}, lost);
  endtask

  task automatic pop_obs();
    sb_pop(t_gate);
    sb_pop(t_sel);
    sb_pop(t_fall);
    sb_pop(t_done);
    sb_pop(n_done);
    sb_pop(n_busy);
    sb_pop(t_err);
    sb_pop(t_lost);
    sb_pop(int'(clk_sel_o));
    sb_pop(int'(error_o));
    sb_pop(int'(lock_lost_o));
  endtask

  // Gate model: ack mirrors the request one cycle later.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_ack) clk_gate_ack = clk_gate_req_o;
  endtask

  task automatic observe(input int n, input int inj_at, input logic inj_tgt);
    logic prev_gate;
    logic prev_sel;
    t_gate = 0; t_sel = 0; t_fall = 0; t_done = 0;
    n_done = 0; n_busy = 0; t_err = 0; t_lost = 0;
    prev_gate = clk_gate_req_o;
    prev_sel  = clk_sel_o;
    for (int i = 1; i <= n; i++) begin
      tick();
      switch_req = 1'b0;
      if (clk_gate_req_o && !prev_gate && t_gate == 0) t_gate = i;
      if (!clk_gate_req_o && prev_gate && t_fall == 0) t_fall = i;
      if (clk_sel_o !== prev_sel && t_sel == 0) t_sel = i;
      if (done_o) begin
        n_done++;
        if (t_done == 0) t_done = i;
      end
      if (busy_o) n_busy++;
      if (error_o && t_err == 0) t_err = i;
      if (lock_lost_o && t_lost == 0) t_lost = i;
      prev_gate = clk_gate_req_o;
      prev_sel  = clk_sel_o;
      if (i == inj_at) begin
        switch_req    = 1'b1;
        switch_target = inj_tgt;
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    auto_ack = 1'b1;
    rst = 1'b1;
    switch_req = 1'b0;
    switch_target = 1'b0;
    fll_lock = 1'b0;
    clk_gate_ack = 1'b0;
    err_clr = 1'b0;

    // Reset values
    #1;
    chk("rst.sel", clk_sel_o, 0);
    chk("rst.gate", clk_gate_req_o, 0);
    chk("rst.busy", busy_o, 0);
    chk("rst.done", done_o, 0);
    chk("rst.err", error_o, 0);
    chk("rst.lost", lock_lost_o, 0);
    tick();
    tick();
    rst = 1'b0;

    // Idle with no lock and sel=0: nothing may happen
    push_exp("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    observe(100, 0, 1'b0);
    pop_obs();

    // Locked switch to clk1
    fll_lock = 1'b1;
    tick(); tick(); tick();
    switch_req = 1'b1;
    switch_target = 1'b1;
    push_exp("sw1", 2, 3, 11, 12, 1, 11, 0, 0, 1, 0, 0);
    observe(14, 0, 1'b0);
    pop_obs();

    // Lock loss fallback; a request in the fallback cycle is dropped
    fll_lock = 1'b0;
    tick(); tick();
    switch_req = 1'b1;
    switch_target = 1'b1;
    push_exp("fallback", 1, 2, 10, 11, 1, 10, 0, 1, 0, 0, 1);
    observe(14, 0, 1'b0);
    pop_obs();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("fallback.lost_clr", lock_lost_o, 0);

    // Lock timeout abort
    switch_req = 1'b1;
    switch_target = 1'b1;
    push_exp("timeout", 0, 0, 0, 0, 0, 16, 17, 0, 0, 1, 0);
    observe(20, 0, 1'b0);
    pop_obs();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("timeout.err_clr", error_o, 0);

    // Request for the current source completes without gating
    switch_req = 1'b1;
    switch_target = 1'b0;
    push_exp("same", 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    observe(4, 0, 1'b0);
    pop_obs();

    // Request injected during SETTLE is ignored
    fll_lock = 1'b1;
    tick(); tick(); tick();
    switch_req = 1'b1;
    switch_target = 1'b1;
    push_exp("busyreq", 2, 3, 11, 12, 1, 11, 0, 0, 1, 0, 0);
    observe(14, 5, 1'b0);
    pop_obs();

    // Switch back to clk0 while locked
    switch_req = 1'b1;
    switch_target = 1'b0;
    push_exp("sw0", 1, 2, 10, 11, 1, 10, 0, 0, 0, 0, 0);
    observe(14, 0, 1'b0);
    pop_obs();

    // Reset mid-SETTLE with sel=1 acts without a clock edge
    switch_req = 1'b1;
    switch_target = 1'b1;
    observe(5, 0, 1'b0);
    chk("midrst.pre_sel", clk_sel_o, 1);
    chk("midrst.pre_gate", clk_gate_req_o, 1);
    chk("midrst.pre_busy", busy_o, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst.sel", clk_sel_o, 0);
    chk("midrst.gate", clk_gate_req_o, 0);
    chk("midrst.busy", busy_o, 0);
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("postrst.sel", clk_sel_o, 0);
    chk("postrst.busy", busy_o, 0);
    chk("postrst.done", done_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
